vmul_group_sequencer: RTL
=========================

VMUL_GROUP_SEQUENCER -- requirements
Module: vmul_group_sequencer

Interface
REQ-001 Parameters SHALL be:
- NUMLANES, 16, vector lanes per op.
- NUMMULLANES, 4, physical multipliers; NUMLANES SHALL be an integer multiple of it.
- MUL_LAT, 2, multiplier issue-to-result cycles, at least 1.
- SKIPMASK, 1, 1 = skip groups whose mask slice is all-zero.

REQ-002 Derived values: NUMGRPS = NUMLANES/NUMMULLANES; GW = max(1, clog2(NUMGRPS)).

REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-high. Ports:
- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-high reset (1 = in reset).
- in_valid  in  1  op request.
- in_ready  out  1  sequencer can accept an op.
- in_vmask  in  NUMLANES  lane mask of the request.
- in_op  in  5  multiplier opcode of the request.
- squash  in  1  synchronous abort of the current op.
- mul_issue  out  1  drive one group into the multipliers this cycle.
- mul_grp  out  GW  group index being issued; covers lanes grp*NUMMULLANES upward.
- mul_op  out  5  latched opcode.
- mul_grp_mask  out  NUMMULLANES  mask slice of the issued group.
- wb_valid  out  1  group result available this cycle.
- wb_grp  out  GW  group index of the result.
- wb_mask  out  NUMMULLANES  mask slice of the result.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high whenever not IDLE.

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, DRAIN and NULL. in_ready SHALL be 1 only in IDLE. busy SHALL be 1 in every state other than IDLE.

REQ-005 Acceptance: in_valid & in_ready & ~squash at an edge SHALL latch in_op and in_vmask. It SHALL load the pending group vector as follows:
- bit g = |in_vmask slice g when SKIPMASK=1;
- all ones when SKIPMASK=0.

REQ-006 Next state after acceptance:
- ISSUE if the pending vector is nonzero;
- NULL otherwise.

REQ-007 In ISSUE, mul_issue SHALL be 1 every cycle, with no bubbles.
- mul_grp SHALL be the lowest-index pending group, and that bit SHALL be cleared at the edge.
- mul_grp_mask SHALL be the latched mask slice of that group, even when SKIPMASK=0.

REQ-008 Issuing the last pending group SHALL move the FSM from ISSUE to DRAIN.

REQ-009 A MUL_LAT-deep shift register SHALL carry {valid, grp, mask, last} from each issue. Its tail SHALL drive wb_valid, wb_grp and wb_mask exactly MUL_LAT cycles after the issue cycle.

REQ-010 done SHALL equal wb_valid & tail.last. The FSM SHALL move from DRAIN to IDLE at the edge ending the done cycle.

REQ-011 NULL SHALL last exactly one cycle with done=1, wb_valid=0 and mul_issue=0, then return to IDLE.

REQ-012 Timing, with acceptance edge = cycle 0 and k = number of pending groups:
- issues in cycles 1..k;
- done in cycle k+MUL_LAT;
- in_ready=1 from cycle k+MUL_LAT+1;
- for k=0: done in cycle 1 and in_ready from cycle 2.

REQ-013 mul_op SHALL hold the latched opcode from cycle 1 until the op returns to IDLE.

REQ-014 Outputs when not in ISSUE:
- mul_issue SHALL be 0;
- mul_grp and mul_grp_mask SHALL be 0.

REQ-015 squash=1 at an edge in any non-IDLE state SHALL:
- clear the pending vector and every shift-register valid bit;
- force IDLE.
From that edge, no further mul_issue, wb_valid or done SHALL occur for the aborted op.

REQ-016 squash in IDLE SHALL block acceptance; in_ready stays 1.

REQ-017 in_valid while busy SHALL be ignored, with no latching; the requester holds the request until in_ready.

REQ-018 wb_valid and done SHALL never be asserted for an op that was not accepted.

Reset
REQ-019 While resetn=1, asynchronously and at once:
- state=IDLE, pending=0, all shift-register entries=0, latched op and mask=0;
- in_ready=1;
- mul_issue, mul_grp, mul_op, mul_grp_mask, wb_valid, wb_grp, wb_mask, done and busy = 0.

REQ-020 Reset asserted mid-op SHALL discard the op; no done SHALL follow after reset is released.

Verification
Defaults for all scenarios: NUMLANES=16, NUMMULLANES=4, MUL_LAT=2, SKIPMASK=1 unless stated.

REQ-021 Full mask: vmask=0xFFFF, op=5 -> mul_grp=0,1,2,3 in cycles 1-4 with mul_grp_mask=0xF and mul_op=5; wb_grp=0..3 in cycles 3-6; done in cycle 6; in_ready in cycle 7.

REQ-022 Sparse mask: vmask=0x0F10 -> issues grp 1 (mask 0x1) in cycle 1 and grp 2 (mask 0xF) in cycle 2; wb in cycles 3 and 4; done in cycle 4.

REQ-023 Zero mask: vmask=0x0000 -> no mul_issue and no wb_valid; done in cycle 1; in_ready in cycle 2.

REQ-024 SKIPMASK=0, vmask=0x0001 -> four issues, grps 0-3, with masks 0x1,0x0,0x0,0x0; done in cycle 6.

REQ-025 Squash: vmask=0xFFFF with squash in cycle 2 -> only grps 0,1 issued; wb_valid never asserted; done never asserted; in_ready=1 in cycle 3.

REQ-026 Reset mid-op: resetn pulsed in cycle 3 of a 0xFFFF op -> all outputs at reset values within the same cycle; no done afterwards; a new op is accepted normally after release.

Source files
------------

// File: rtl/vmul_group_sequencer.sv
// vmul_group_sequencer
//   Breaks one vector multiply op into groups of NUMMULLANES lanes. It issues
//   one group per cycle into a shared multiplier array, and it tracks the
//   results through a MUL_LAT-deep pipe so it can report writebacks and a
//   single done pulse.
//
// Handshake: an op is taken on a rising edge where in_valid & in_ready & ~squash.
//   in_ready is high only while idle. The requester holds in_valid, in_vmask
//   and in_op stable until in_ready is seen. in_valid seen while busy has no
//   effect.
//
// Ports
//   clk, resetn        clock; asynchronous reset, active high despite the name
//   in_valid/in_ready  op request handshake; in_vmask lane mask, in_op opcode
//   squash             synchronous abort of the op in flight
//   mul_issue/mul_grp/mul_op/mul_grp_mask   group driven into the multipliers
//   wb_valid/wb_grp/wb_mask                 group result, MUL_LAT after issue
//   done               one-cycle completion pulse; busy = not idle
module vmul_group_sequencer #(
  parameter int NUMLANES    = 16,
  parameter int NUMMULLANES = 4,
  parameter int MUL_LAT     = 2,
  parameter int SKIPMASK    = 1,
  localparam int NUMGRPS    = NUMLANES / NUMMULLANES,
  localparam int GW         = (NUMGRPS > 1) ? $clog2(NUMGRPS) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUMLANES-1:0]    in_vmask,
  input  logic [4:0]             in_op,
  input  logic                   squash,
  output logic                   mul_issue,
  output logic [GW-1:0]          mul_grp,
  output logic [4:0]             mul_op,
  output logic [NUMMULLANES-1:0] mul_grp_mask,
  output logic                   wb_valid,
  output logic [GW-1:0]          wb_grp,
  output logic [NUMMULLANES-1:0] wb_mask,
  output logic                   done,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_NULL} state_t;

  state_t state_q, state_d;

  logic [NUMGRPS-1:0]  pending_q;
  logic [4:0]          op_q;
  logic [NUMLANES-1:0] mask_q;

  // Result tracking pipe: entry 0 is loaded at the end of the issue cycle,
  // so the last entry lines up with the multiplier output.
  logic [MUL_LAT-1:0]                  sr_valid_q;
  logic [MUL_LAT-1:0][GW-1:0]          sr_grp_q;
  logic [MUL_LAT-1:0][NUMMULLANES-1:0] sr_mask_q;
  logic [MUL_LAT-1:0]                  sr_last_q;

  logic [NUMGRPS-1:0]     load_vec;
  logic [NUMGRPS-1:0]     issue_onehot;
  logic [GW-1:0]          issue_grp;
  logic [NUMMULLANES-1:0] issue_slice;
  logic                   found;
  logic                   last_issue;
  logic                   accept;
  logic                   squash_busy;

  assign accept      = in_valid & in_ready & ~squash;
  assign squash_busy = squash & (state_q != S_IDLE);

  // Pending-vector load value and lowest-index pending group pick.
  always_comb begin
    load_vec     = '0;
    issue_onehot = '0;
    issue_grp    = '0;
    issue_slice  = '0;
    found        = 1'b0;
    for (int g = 0; g < NUMGRPS; g++) begin
      load_vec[g] = (SKIPMASK != 0) ? |in_vmask[g*NUMMULLANES +: NUMMULLANES] : 1'b1;
      if (pending_q[g] && !found) begin
        found           = 1'b1;
        issue_onehot[g] = 1'b1;
        issue_grp       = GW'(g);
        issue_slice     = mask_q[g*NUMMULLANES +: NUMMULLANES];
      end
    end
  end

  assign last_issue = ~|(pending_q & ~issue_onehot);

  assign in_ready     = (state_q == S_IDLE);
  assign busy         = ~in_ready;
  assign mul_issue    = (state_q == S_ISSUE);
  assign mul_grp      = mul_issue ? issue_grp : '0;
  assign mul_grp_mask = mul_issue ? issue_slice : '0;
  assign mul_op       = op_q;
  assign wb_valid     = sr_valid_q[MUL_LAT-1];
  assign wb_grp       = sr_grp_q[MUL_LAT-1];
  assign wb_mask      = sr_mask_q[MUL_LAT-1];
  assign done         = (state_q == S_NULL) | (wb_valid & sr_last_q[MUL_LAT-1]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (|load_vec) ? S_ISSUE : S_NULL;
      S_ISSUE: if (last_issue) state_d = S_DRAIN;
      S_DRAIN: if (done) state_d = S_IDLE;
      S_NULL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (squash_busy) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      pending_q  <= '0;
      op_q       <= '0;
      mask_q     <= '0;
      sr_valid_q <= '0;
      sr_grp_q   <= '0;
      sr_mask_q  <= '0;
      sr_last_q  <= '0;
    end else begin
      if (accept) begin
        op_q      <= in_op;
        mask_q    <= in_vmask;
        pending_q <= load_vec;
      end else if (squash_busy) begin
        pending_q <= '0;
      end else if (mul_issue) begin
        pending_q <= pending_q & ~issue_onehot;
      end

      // An abort wipes the whole pipe, including the group issued this cycle.
      if (squash_busy) begin
        sr_valid_q <= '0;
        sr_grp_q   <= '0;
        sr_mask_q  <= '0;
        sr_last_q  <= '0;
      end else begin
        sr_valid_q[0] <= mul_issue;
        sr_grp_q[0]   <= mul_grp;
        sr_mask_q[0]  <= mul_grp_mask;
        sr_last_q[0]  <= mul_issue & last_issue;
        for (int i = 1; i < MUL_LAT; i++) begin
          sr_valid_q[i] <= sr_valid_q[i-1];
          sr_grp_q[i]   <= sr_grp_q[i-1];
          sr_mask_q[i]  <= sr_mask_q[i-1];
          sr_last_q[i]  <= sr_last_q[i-1];
        end
      end
    end
  end

endmodule
